// File: rtl/reset_cond.sv
// Reset conditioner: per-source sync + debounce, masked combine, minimum stretch, cause/count report.
// Optional RESET_COND_FAST_ASSERT_EN: masked source assertion bypasses the debounce counter.
module reset_cond #(
  parameter int NUM_SRC      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_W   = 18,
  parameter int DEBOUNCE_CYC = 160000,
  parameter int STRETCH_W    = 16,
  parameter int STRETCH_CYC  = 16000
) (
  input  logic               clock_160,
  input  logic               inp_resn,
  input  logic [NUM_SRC-1:0] src_resn,
  input  logic [NUM_SRC-1:0] src_mask,
  output logic               out_resn,
  output logic [NUM_SRC-1:0] src_status,
  output logic [NUM_SRC-1:0] last_cause,
  output logic [7:0]         rst_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STRETCH = 2'd2
  } state_t;

  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYC - 1);
  localparam logic [STRETCH_W-1:0]  ST_LAST = STRETCH_W'(STRETCH_CYC - 1);

  logic [NUM_SRC-1:0] w_status_next;
  logic [NUM_SRC-1:0] w_act;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SYNC_STAGES-1:0] r_sync;
      logic [DEBOUNCE_W-1:0]  r_db_cnt;
      logic [DEBOUNCE_W-1:0]  w_db_cnt_next;
      logic                   r_status;
      logic                   w_status_nxt;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
          r_sync   <= '1;
          r_db_cnt <= '0;
          r_status <= 1'b1;
        end else begin
          r_sync   <= {r_sync[SYNC_STAGES-2:0], src_resn[gi]};
          r_db_cnt <= w_db_cnt_next;
          r_status <= w_status_nxt;
        end
      end

      always_comb begin
        w_db_cnt_next = '0;
        w_status_nxt  = r_status;
        if (w_s != r_status) begin
          if (r_db_cnt == DB_LAST) begin
            w_status_nxt = w_s;
          end else begin
            w_db_cnt_next = r_db_cnt + 1'b1;
          end
        end
`ifdef RESET_COND_FAST_ASSERT_EN
        if (src_mask[gi] && !w_s && r_status) begin
          w_status_nxt  = 1'b0;
          w_db_cnt_next = '0;
        end
`endif
      end

      assign src_status[gi]    = r_status;
      assign w_status_next[gi] = w_status_nxt;
    end
  endgenerate

  // The FSM sees the status value being loaded this edge, so out_resn moves on the same
  // edge a debounced level change is accepted.
  assign w_act = src_mask & ~w_status_next;

  state_t               r_state, w_state_next;
  logic [STRETCH_W-1:0] r_stretch_cnt, w_stretch_next;
  logic [NUM_SRC-1:0]   r_last_cause, w_cause_next;
  logic [7:0]           r_rst_count, w_count_next;
  logic                 r_out_resn;

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_state       <= ST_STRETCH;
      r_stretch_cnt <= '0;
      r_last_cause  <= '0;
      r_rst_count   <= '0;
      r_out_resn    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_stretch_cnt <= w_stretch_next;
      r_last_cause  <= w_cause_next;
      r_rst_count   <= w_count_next;
      r_out_resn    <= (w_state_next == ST_RUN);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_stretch_next = r_stretch_cnt;
    w_cause_next   = r_last_cause;
    w_count_next   = r_rst_count;
    case (r_state)
      ST_RUN: begin
        if (|w_act) begin
          w_state_next = ST_HOLD;
          w_cause_next = w_act;
          if (r_rst_count != 8'hFF) begin
            w_count_next = r_rst_count + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        w_cause_next = r_last_cause | w_act;
        if (w_act == '0) begin
          w_state_next   = ST_STRETCH;
          w_stretch_next = '0;
        end
      end
      ST_STRETCH: begin
        if (|w_act) begin
          w_state_next   = ST_HOLD;
          w_stretch_next = '0;
          w_cause_next   = r_last_cause | w_act;
        end else if (r_stretch_cnt == ST_LAST) begin
          w_state_next = ST_RUN;
        end else begin
          w_stretch_next = r_stretch_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_STRETCH;
        w_stretch_next = '0;
      end
    endcase
  end

  assign out_resn   = r_out_resn;
  assign last_cause = r_last_cause;
  assign rst_count  = r_rst_count;

endmodule

// File: tb/tb_reset_cond.sv
// Directed bench for reset_cond with DEBOUNCE_CYC=4, STRETCH_CYC=8, two sources.
module tb_reset_cond;

`ifdef RESET_COND_FAST_ASSERT_EN
  localparam int ALAT = 3;
`else
  localparam int ALAT = 6;
`endif

  logic       clk = 1'b0;
  logic       inp_resn;
  logic [1:0] src_resn;
  logic [1:0] src_mask;
  logic       out_resn;
  logic [1:0] src_status;
  logic [1:0] last_cause;
  logic [7:0] rst_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_cond #(
    .NUM_SRC(2), .SYNC_STAGES(2), .DEBOUNCE_W(4), .DEBOUNCE_CYC(4),
    .STRETCH_W(8), .STRETCH_CYC(8)
  ) dut (
    .clock_160 (clk),
    .inp_resn  (inp_resn),
    .src_resn  (src_resn),
    .src_mask  (src_mask),
    .out_resn  (out_resn),
    .src_status(src_status),
    .last_cause(last_cause),
    .rst_count (rst_count)
  );

  typedef struct {
    logic [1:0] src;
    logic [1:0] mask;
    int         ncyc;
    logic       exp_out;
    logic [1:0] exp_status;
    logic [1:0] exp_cause;
    logic [7:0] exp_count;
  } vec_t;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic stayed_high;

    inp_resn = 1'b0;
    src_resn = 2'b11;
    src_mask = 2'b11;
    tick(5);
    chk("rst_out", 32'(out_resn), 32'h0);
    chk("rst_status", 32'(src_status), 32'h3);
    chk("rst_cause", 32'(last_cause), 32'h0);
    chk("rst_count", 32'(rst_count), 32'h0);

    // Power-on: out_resn rises on the 8th edge after release
    inp_resn = 1'b1;
    tick(7);
    chk("por_low_edge7", 32'(out_resn), 32'h0);
    tick(1);
    chk("por_high_edge8", 32'(out_resn), 32'h1);
    chk("por_cause", 32'(last_cause), 32'h0);
    chk("por_count", 32'(rst_count), 32'h0);

`ifndef RESET_COND_FAST_ASSERT_EN
    // Bounce: 3 low samples is one short of the debounce threshold
    stayed_high = 1'b1;
    src_resn[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) src_resn[0] = 1'b1;
      tick(1);
      if (out_resn !== 1'b1) stayed_high = 1'b0;
    end
    chk("bounce_out_stayed_high", 32'(stayed_high), 32'h1);
    chk("bounce_status", 32'(src_status), 32'h3);
    chk("bounce_count", 32'(rst_count), 32'h0);
`endif

    // src1 held low 20 cycles
    src_resn[1] = 1'b0;
    tick(ALAT - 1);
    chk("s1_pre_status", 32'(src_status), 32'h3);
    chk("s1_pre_out", 32'(out_resn), 32'h1);
    tick(1);
    chk("s1_assert_status", 32'(src_status), 32'h1);
    chk("s1_assert_out", 32'(out_resn), 32'h0);
    chk("s1_assert_cause", 32'(last_cause), 32'h2);
    chk("s1_assert_count", 32'(rst_count), 32'h1);
    tick(20 - ALAT);
    src_resn[1] = 1'b1;
    tick(5);
    chk("s1_rel_pre_status", 32'(src_status), 32'h1);
    tick(1);
    chk("s1_rel_status", 32'(src_status), 32'h3);
    chk("s1_rel_out", 32'(out_resn), 32'h0);

    // src0 asserts during the stretch: back to HOLD, fresh stretch
    src_resn[0] = 1'b0;
    tick(6);
    chk("re_cause", 32'(last_cause), 32'h3);
    chk("re_count", 32'(rst_count), 32'h1);
    chk("re_out", 32'(out_resn), 32'h0);
    src_resn[0] = 1'b1;
    tick(2);
    chk("re_old_stretch_end_out", 32'(out_resn), 32'h0);
    tick(11);
    chk("re_fresh_edge7_out", 32'(out_resn), 32'h0);
    tick(1);
    chk("re_fresh_edge8_out", 32'(out_resn), 32'h1);
    chk("re_final_count", 32'(rst_count), 32'h1);
    chk("re_final_cause", 32'(last_cause), 32'h3);

    // Masked-off source is tracked but ignored
    src_mask = 2'b01;
    src_resn[1] = 1'b0;
    stayed_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) src_resn[1] = 1'b1;
      tick(1);
      if (out_resn !== 1'b1) stayed_high = 1'b0;
      if (i == 5) chk("mask_status_tracks", 32'(src_status), 32'h1);
    end
    chk("mask_out_stayed_high", 32'(stayed_high), 32'h1);
    chk("mask_count", 32'(rst_count), 32'h1);
    chk("mask_status_final", 32'(src_status), 32'h3);

    vecs[0] = '{2'b10, 2'b11, 10, 1'b0, 2'b10, 2'b01, 8'd2};
    vecs[1] = '{2'b11, 2'b11, 20, 1'b1, 2'b11, 2'b01, 8'd2};
    vecs[2] = '{2'b01, 2'b01, 10, 1'b1, 2'b01, 2'b01, 8'd2};
    vecs[3] = '{2'b01, 2'b11,  3, 1'b0, 2'b01, 2'b10, 8'd3};
    vecs[4] = '{2'b01, 2'b01,  8, 1'b0, 2'b01, 2'b10, 8'd3};
    vecs[5] = '{2'b01, 2'b01,  1, 1'b1, 2'b01, 2'b10, 8'd3};
    vecs[6] = '{2'b11, 2'b01, 12, 1'b1, 2'b11, 2'b10, 8'd3};
    vecs[7] = '{2'b00, 2'b11, 10, 1'b0, 2'b00, 2'b11, 8'd4};
    for (int v = 0; v < 8; v++) begin
      src_resn = vecs[v].src;
      src_mask = vecs[v].mask;
      tick(vecs[v].ncyc);
      chk($sformatf("vec%0d_out", v), 32'(out_resn), 32'(vecs[v].exp_out));
      chk($sformatf("vec%0d_status", v), 32'(src_status), 32'(vecs[v].exp_status));
      chk($sformatf("vec%0d_cause", v), 32'(last_cause), 32'(vecs[v].exp_cause));
      chk($sformatf("vec%0d_count", v), 32'(rst_count), 32'(vecs[v].exp_count));
    end
    src_resn = 2'b11;
    src_mask = 2'b11;
    tick(20);
    chk("after_vec_out", 32'(out_resn), 32'h1);

    // 300 src0 resets saturate the counter
    for (int n = 0; n < 300; n++) begin
      src_resn = 2'b10;
      tick(8);
      src_resn = 2'b11;
      tick(16);
    end
    chk("sat_count", 32'(rst_count), 32'hFF);
    chk("sat_out", 32'(out_resn), 32'h1);
    chk("sat_cause", 32'(last_cause), 32'h1);

    // Asynchronous global reset mid-run, between clock edges
    #2;
    inp_resn = 1'b0;
    #1;
    chk("async_out", 32'(out_resn), 32'h0);
    chk("async_count", 32'(rst_count), 32'h0);
    chk("async_cause", 32'(last_cause), 32'h0);
    chk("async_status", 32'(src_status), 32'h3);
    tick(2);
    inp_resn = 1'b1;
    tick(8);
    chk("async_recover_out", 32'(out_resn), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
